// File: rtl/data_memory_responder.sv
// Byte-wide RAM that answers exec-unit reads and writes. It also clears itself after reset and can take a streamed program load.
// Optional macro MEM_WRITE_FORWARD_EN: a read and a write to the same address in one cycle return the write data.
module data_memory_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_ram_en,
    input  logic [ADDR_BITS-1:0] rd_ram_addr,
    output logic [DATA_BITS-1:0] rd_ram_data,
    input  logic                 wr_ram_en,
    input  logic [ADDR_BITS-1:0] wr_ram_addr,
    input  logic [DATA_BITS-1:0] wr_ram_data,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_overflow,
    output logic                 busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_READY, S_LOAD} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     clr_ptr_q, clr_ptr_d;
    logic [PTR_W-1:0]     load_ptr_q, load_ptr_d;
    logic                 load_overflow_q, load_overflow_d;
    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 rd_in_range, wr_in_range;
    logic                 mem_we;
    logic [PTR_W-1:0]     mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;

    assign rd_in_range   = (int'(rd_ram_addr) < DEPTH);
    assign wr_in_range   = (int'(wr_ram_addr) < DEPTH);
    assign load_overflow = load_overflow_q;

    // NOTE: only control state is reset; the array is zeroed by the CLEAR sweep, never by reset itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_CLEAR;
            clr_ptr_q       <= '0;
            load_ptr_q      <= '0;
            load_overflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_ptr_q       <= clr_ptr_d;
            load_ptr_q      <= load_ptr_d;
            load_overflow_q <= load_overflow_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        clr_ptr_d       = clr_ptr_q;
        load_ptr_d      = load_ptr_q;
        load_overflow_d = load_overflow_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_ptr_q == LAST_IDX) begin
                    clr_ptr_d = '0;
                    state_d   = S_READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
            S_READY: begin
                if (load_start) begin
                    state_d         = S_LOAD;
                    load_ptr_d      = '0;
                    load_overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    // The pointer wraps explicitly, so a DEPTH that is not a power of two still works.
                    if (load_ptr_q == LAST_IDX) begin
                        load_ptr_d      = '0;
                        load_overflow_d = 1'b1;
                    end else begin
                        load_ptr_d = load_ptr_q + PTR_W'(1);
                    end
                    if (load_last) state_d = S_READY;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_READY);
        load_ready = (state_q == S_LOAD);
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
            end
            S_LOAD: begin
                mem_we    = load_valid;
                mem_waddr = load_ptr_q;
                mem_wdata = load_data;
            end
            S_READY: begin
                mem_we    = wr_ram_en && wr_in_range;
                mem_waddr = wr_ram_addr[PTR_W-1:0];
                mem_wdata = wr_ram_data;
            end
            default: mem_we = 1'b0;
        endcase
        // A write in the same cycle as reset would be discarded anyway, so it is suppressed here.
        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        rd_ram_data = '0;
        if (rd_ram_en && rd_in_range && (state_q == S_READY)) begin
            rd_ram_data = mem[rd_ram_addr[PTR_W-1:0]];
`ifdef MEM_WRITE_FORWARD_EN
            if (wr_ram_en && wr_in_range && (wr_ram_addr == rd_ram_addr))
                rd_ram_data = wr_ram_data;
`endif
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder. It drives a DEPTH=256 instance and a DEPTH=4 instance from shared buses with separate resets.
// The stimulus pushes expectations taken from an array model, and a negedge monitor pops and compares them.
module tb_data_memory_responder;

    localparam int D0 = 256;
    localparam int D1 = 4;
`ifdef MEM_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rd_en, wr_en, load_start, load_valid, load_last;
    logic [7:0] rd_addr, wr_addr, wr_data, load_data;
    logic [7:0] rd_data0, rd_data1;
    logic       ready0, ready1, ovf0, ovf1, busy0, busy1;

    data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .DEPTH(D0)) u_dut0 (
        .clk(clk), .reset(rst0),
        .rd_ram_en(rd_en), .rd_ram_addr(rd_addr), .rd_ram_data(rd_data0),
        .wr_ram_en(wr_en), .wr_ram_addr(wr_addr), .wr_ram_data(wr_data),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(ready0), .load_overflow(ovf0), .busy(busy0)
    );

    data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .DEPTH(D1)) u_dut1 (
        .clk(clk), .reset(rst1),
        .rd_ram_en(rd_en), .rd_ram_addr(rd_addr), .rd_ram_data(rd_data1),
        .wr_ram_en(wr_en), .wr_ram_addr(wr_addr), .wr_ram_data(wr_data),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(ready1), .load_overflow(ovf1), .busy(busy1)
    );

    typedef enum int {K_RD, K_BUSY, K_READY, K_OVF} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        int          unit;
        logic [31:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model: plain array contents plus loader pointer and overflow flag for each instance.
    logic [7:0] mdl [2][256];
    int         mdl_ptr [2];
    logic       mdl_ovf [2];

    function automatic int depth_of(int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic logic [31:0] obs(kind_e k, int u);
        case (k)
            K_RD:    return 32'((u == 0) ? rd_data0 : rd_data1);
            K_BUSY:  return 32'((u == 0) ? busy0 : busy1);
            K_READY: return 32'((u == 0) ? ready0 : ready1);
            default: return 32'((u == 0) ? ovf0 : ovf1);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, obs(mon_e.kind, mon_e.unit), mon_e.exp);
        end
    end

    task automatic expect_val(string name, kind_e k, int u, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = k;
        e.unit = u;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    endtask

    // Reset pulse. The CLEAR phase must then hold busy high for exactly DEPTH cycles and leave the memory all zero.
    task automatic reset_and_clear(int u);
        int cnt;
        if (u == 0) rst0 = 1'b1; else rst1 = 1'b1;
        step();
        if (u == 0) rst0 = 1'b0; else rst1 = 1'b0;
        idle_inputs();
        for (int i = 0; i < 256; i++) mdl[u][i] = 8'h00;
        mdl_ptr[u] = 0;
        mdl_ovf[u] = 1'b0;
        expect_val("reset_busy", K_BUSY, u, 1);
        expect_val("reset_load_ready", K_READY, u, 0);
        expect_val("reset_overflow", K_OVF, u, 0);
        cnt = 0;
        for (int g = 0; g < 4 * D0 + 16; g++) begin
            if (((u == 0) ? busy0 : busy1) !== 1'b1) break;
            cnt++;
            step();
        end
        check("clear_cycles", cnt, depth_of(u));
    endtask

    task automatic rd_chk(string name, int u, logic [7:0] a, logic en);
        rd_en   = en;
        rd_addr = a;
        expect_val(name, K_RD, u, 32'((en && int'(a) < depth_of(u)) ? mdl[u][a] : 8'h00));
        step();
        rd_en = 1'b0;
    endtask

    task automatic wr_do(int u, logic [7:0] a, logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        if (int'(a) < depth_of(u)) mdl[u][a] = d;
    endtask

    task automatic load_stream(int u, input logic [7:0] bytes [$], int max_gap);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        mdl_ptr[u] = 0;
        mdl_ovf[u] = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                load_valid = 1'b0;
                expect_val("load_ready_stall", K_READY, u, 1);
                step();
            end
            load_valid = 1'b1;
            load_data  = bytes[i];
            load_last  = (i == bytes.size() - 1);
            expect_val("load_busy", K_BUSY, u, 1);
            step();
            mdl[u][mdl_ptr[u]] = bytes[i];
            if (mdl_ptr[u] == depth_of(u) - 1) begin
                mdl_ptr[u] = 0;
                mdl_ovf[u] = 1'b1;
            end else begin
                mdl_ptr[u]++;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        expect_val("busy_after_load", K_BUSY, u, 0);
        expect_val("load_overflow", K_OVF, u, 32'(mdl_ovf[u]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q [$];
        logic       w_en, r_en;
        logic [7:0] wa, wd, ra, e;
        int         n;

        rst0 = 1'b1;
        rst1 = 1'b1;
        idle_inputs();
        step();

        reset_and_clear(0);
        rd_chk("rd_after_clear_00", 0, 8'h00, 1'b1);
        rd_chk("rd_after_clear_ff", 0, 8'hFF, 1'b1);

        q = '{8'hA0, 8'h12, 8'hB5, 8'h34};
        load_stream(0, q, 3);
        for (int i = 0; i < 4; i++) rd_chk("rd_loaded", 0, 8'(i), 1'b1);

        wr_do(0, 8'h10, 8'h5A);
        rd_chk("rd_after_write", 0, 8'h10, 1'b1);
        rd_chk("rd_disabled", 0, 8'h10, 1'b0);

        // A CPU read and write issued while LOAD is running must both be ignored.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        rd_en = 1'b1; rd_addr = 8'h10;
        wr_en = 1'b1; wr_addr = 8'h30; wr_data = 8'h99;
        expect_val("rd_while_busy", K_RD, 0, 0);
        step();
        idle_inputs();
        load_valid = 1'b1; load_data = 8'h66; load_last = 1'b1;
        step();
        mdl[0][0] = 8'h66;
        idle_inputs();
        expect_val("busy_after_short_load", K_BUSY, 0, 0);
        rd_chk("wr_while_busy_dropped", 0, 8'h30, 1'b1);
        rd_chk("rd_0x10_kept", 0, 8'h10, 1'b1);
        rd_chk("rd_reloaded_0", 0, 8'h00, 1'b1);

        // Read and write the same address in the same cycle.
        wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h77;
        rd_en = 1'b1; rd_addr = 8'h20;
        expect_val("same_cycle_rw", K_RD, 0, 32'(FWD ? 8'h77 : mdl[0][8'h20]));
        step();
        idle_inputs();
        mdl[0][8'h20] = 8'h77;
        rd_chk("rd_after_same_cycle", 0, 8'h20, 1'b1);

        for (int i = 0; i < 300; i++) begin
            w_en = 1'($urandom_range(0, 1));
            wa   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            wd   = 8'($urandom);
            r_en = ($urandom_range(0, 3) != 0);
            ra   = ($urandom_range(0, 2) == 0) ? wa : 8'($urandom_range(0, 31));
            wr_en = w_en; wr_addr = wa; wr_data = wd;
            rd_en = r_en; rd_addr = ra;
            if (!r_en)                      e = 8'h00;
            else if (w_en && wa == ra && FWD) e = wd;
            else                            e = mdl[0][ra];
            expect_val("random_rw", K_RD, 0, 32'(e));
            step();
            if (w_en) mdl[0][wa] = wd;
        end
        idle_inputs();

        n = $urandom_range(1, 8);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        load_stream(0, q, 2);
        for (int i = 0; i < 10; i++) rd_chk("rd_random_load", 0, 8'(i), 1'b1);

        // Reset arrives after two of four loader bytes; the partial load is discarded.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 8'hC0 + 8'(i);
            step();
        end
        load_valid = 1'b1; load_data = 8'hC2;
        reset_and_clear(0);
        rd_chk("rd_after_abort_0", 0, 8'h00, 1'b1);
        rd_chk("rd_after_abort_1", 0, 8'h01, 1'b1);
        rd_chk("rd_after_abort_10", 0, 8'h10, 1'b1);
        rd_chk("rd_after_abort_20", 0, 8'h20, 1'b1);
        rd_chk("rd_after_abort_ff", 0, 8'hFF, 1'b1);

        // From here on the DEPTH=4 instance is tested while the large one is held in reset.
        rst0 = 1'b1;
        reset_and_clear(1);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_stream(1, q, 0);
        for (int i = 0; i < 4; i++) rd_chk("d4_rd_wrapped", 1, 8'(i), 1'b1);
        wr_do(1, 8'h04, 8'hAA);
        rd_chk("d4_rd_out_of_range", 1, 8'h04, 1'b1);
        wr_do(1, 8'h84, 8'hBB);
        rd_chk("d4_alias_write_dropped", 1, 8'h00, 1'b1);
        wr_en = 1'b1; wr_addr = 8'h04; wr_data = 8'hCC;
        rd_en = 1'b1; rd_addr = 8'h04;
        expect_val("d4_same_cycle_oob", K_RD, 1, 0);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) rd_chk("d4_rd_final", 1, 8'(i), 1'b1);

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
